// File: rtl/instr_decode_stage_pkg.sv
// ----------------------------------------------------------------------------
// instr_decode_stage_pkg
//   Shared definitions for the decode front end: RV32 major opcode constants,
//   the 3-bit immediate-format encoding used by the decoder, the immediate
//   generator and the execute stage, the decoded bundle layout and the
//   skid-buffer state type.
// ----------------------------------------------------------------------------
package instr_decode_stage_pkg;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    // Immediate format encodings
    localparam logic [2:0] IMM_NONE = 3'b000;  // no immediate, value 0
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;
    localparam logic [2:0] IMM_Z    = 3'b110;  // CSR zimm, zero-extended rs1 field

    // Skid buffer occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    // One decoded instruction as held in OUT or SKID
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  imm_type;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic        illegal;
    } bundle_t;

    // True for every opcode the decoder recognises
    function automatic logic opcode_known(input logic [6:0] opc);
        logic known;
        known = 1'b0;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_STORE, OPC_BRANCH,
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_SYSTEM, OPC_OP, OPC_FENCE:
                known = 1'b1;
            default:
                known = 1'b0;
        endcase
        return known;
    endfunction

    // Immediate format for a recognised opcode. SYSTEM splits on funct3[2]:
    // the immediate-operand CSR forms carry a 5-bit zimm, the rest (register
    // CSR forms, ECALL/EBREAK) use the I-type CSR/funct12 field.
    function automatic logic [2:0] imm_type_of(input logic [6:0] opc,
                                               input logic [2:0] funct3);
        logic [2:0] t;
        t = IMM_NONE;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: t = IMM_I;
            OPC_STORE:                      t = IMM_S;
            OPC_BRANCH:                     t = IMM_B;
            OPC_LUI, OPC_AUIPC:             t = IMM_U;
            OPC_JAL:                        t = IMM_J;
            OPC_SYSTEM:                     t = funct3[2] ? IMM_Z : IMM_I;
            default:                        t = IMM_NONE;
        endcase
        return t;
    endfunction

endpackage : instr_decode_stage_pkg

// File: rtl/instr_decode_stage_imm_generator.sv
// ----------------------------------------------------------------------------
// imm_generator
//   Purely combinational immediate former. Builds the 32-bit immediate for a
//   given format from instruction bits [31:7].
//   Ports:
//     instr_bits [31:7]  instruction bits above the opcode
//     imm_type   [2:0]   immediate format (IMM_* encodings)
//     imm        [31:0]  formed immediate (0 for IMM_NONE / unknown codes)
// ----------------------------------------------------------------------------
module imm_generator
    import instr_decode_stage_pkg::*;
(
    input  logic [31:7] instr_bits,
    input  logic [2:0]  imm_type,
    output logic [31:0] imm
);

    logic sign;
    assign sign = instr_bits[31];

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I: imm = {{20{sign}}, instr_bits[31:20]};
            IMM_S: imm = {{20{sign}}, instr_bits[31:25], instr_bits[11:7]};
            IMM_B: imm = {{19{sign}}, sign, instr_bits[7], instr_bits[30:25],
                          instr_bits[11:8], 1'b0};
            IMM_U: imm = {instr_bits[31:12], 12'h000};
            IMM_J: imm = {{11{sign}}, sign, instr_bits[19:12], instr_bits[20],
                          instr_bits[30:21], 1'b0};
            IMM_Z: imm = {27'd0, instr_bits[19:15]};
            default: imm = '0;
        endcase
    end

endmodule : imm_generator

// File: rtl/instr_decode_stage.sv
// ----------------------------------------------------------------------------
// instr_decode_stage
//   RV32 decode stage with a 2-entry skid buffer (OUT + SKID) and one cycle of
//   latency. The entering instruction is decoded combinationally and the
//   decoded bundle is what gets stored, so the registers drive the outputs
//   directly.
//   Ports:
//     clk_in, rst_in             clock, synchronous active-high reset
//     instr_in, pc_in, valid_in  upstream instruction offer
//     ready_out                  registered, low only while SKID is occupied
//     valid_out, ready_in        downstream handshake
//     flush_in                   discard everything held and offered
//     pc_out .. illegal_out      decoded bundle (from OUT)
// ----------------------------------------------------------------------------
module instr_decode_stage
    import instr_decode_stage_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_in,
    input  logic        valid_in,
    output logic        ready_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic        flush_in,
    output logic [31:0] pc_out,
    output logic [31:0] imm_out,
    output logic [2:0]  imm_type_out,
    output logic [6:0]  opcode_out,
    output logic [2:0]  funct3_out,
    output logic [6:0]  funct7_out,
    output logic [4:0]  rd_addr_out,
    output logic [4:0]  rs1_addr_out,
    output logic [4:0]  rs2_addr_out,
    output logic        illegal_out
);

    // ------------------------------------------------------------------
    // Combinational decode of the offered instruction
    // ------------------------------------------------------------------
    logic        dec_illegal;
    logic [2:0]  dec_imm_type;
    logic [31:0] dec_imm;
    bundle_t     dec_bundle;

    always_comb begin
        dec_illegal  = (instr_in[1:0] != 2'b11) || !opcode_known(instr_in[6:0]);
        // Illegal encodings force format NONE so the generator yields zero
        dec_imm_type = dec_illegal ? IMM_NONE
                                   : imm_type_of(instr_in[6:0], instr_in[14:12]);
    end

    imm_generator u_imm_generator (
        .instr_bits (instr_in[31:7]),
        .imm_type   (dec_imm_type),
        .imm        (dec_imm)
    );

    always_comb begin
        dec_bundle          = '0;
        dec_bundle.pc       = pc_in;
        dec_bundle.imm      = dec_imm;
        dec_bundle.imm_type = dec_imm_type;
        dec_bundle.opcode   = instr_in[6:0];
        dec_bundle.funct3   = instr_in[14:12];
        dec_bundle.funct7   = instr_in[31:25];
        dec_bundle.rd_addr  = instr_in[11:7];
        dec_bundle.rs1_addr = instr_in[19:15];
        dec_bundle.rs2_addr = instr_in[24:20];
        dec_bundle.illegal  = dec_illegal;
    end

    // ------------------------------------------------------------------
    // Skid buffer control
    // ------------------------------------------------------------------
    skid_state_t state_reg, state_next;
    bundle_t     out_reg;
    bundle_t     skid_reg;
    logic        ready_reg;

    logic accept;
    logic consume;
    logic load_out_new;
    logic load_out_skid;
    logic load_skid;
    logic clear_all;

    assign valid_out = (state_reg != ST_EMPTY);
    assign ready_out = ready_reg;
    assign accept    = valid_in && ready_reg;
    assign consume   = valid_out && ready_in;

    always_comb begin
        state_next    = state_reg;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        clear_all     = 1'b0;

        if (flush_in) begin
            state_next = ST_EMPTY;
            clear_all  = 1'b1;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (accept) begin
                        state_next   = ST_ONE;
                        load_out_new = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        load_out_new = 1'b1;
                    end else if (accept) begin
                        state_next = ST_FULL;
                        load_skid  = 1'b1;
                    end else if (consume) begin
                        state_next = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // ready_out is low here, so no accept can coincide
                    if (consume) begin
                        state_next    = ST_ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                    clear_all  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_reg <= ST_EMPTY;
            ready_reg <= 1'b1;
            out_reg   <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next != ST_FULL);
            if (clear_all) begin
                out_reg  <= '0;
                skid_reg <= '0;
            end else begin
                if (load_out_new) begin
                    out_reg <= dec_bundle;
                end else if (load_out_skid) begin
                    out_reg <= skid_reg;
                end
                if (load_skid) begin
                    skid_reg <= dec_bundle;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bundle outputs
    // ------------------------------------------------------------------
    assign pc_out       = out_reg.pc;
    assign imm_out      = out_reg.imm;
    assign imm_type_out = out_reg.imm_type;
    assign opcode_out   = out_reg.opcode;
    assign funct3_out   = out_reg.funct3;
    assign funct7_out   = out_reg.funct7;
    assign rd_addr_out  = out_reg.rd_addr;
    assign rs1_addr_out = out_reg.rs1_addr;
    assign rs2_addr_out = out_reg.rs2_addr;
    assign illegal_out  = out_reg.illegal;

endmodule : instr_decode_stage

// File: tb/tb_instr_decode_stage.sv
// ----------------------------------------------------------------------------
// tb_instr_decode_stage
//   Directed-vector bench for instr_decode_stage with hand-computed expected
//   values. Inputs change 1 ns after a rising edge; outputs are checked at the
//   same point, so each check reflects the edge just taken.
// ----------------------------------------------------------------------------
module tb_instr_decode_stage;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] instr_in;
    logic [31:0] pc_in;
    logic        valid_in;
    logic        ready_out;
    logic        valid_out;
    logic        ready_in;
    logic        flush_in;
    logic [31:0] pc_out;
    logic [31:0] imm_out;
    logic [2:0]  imm_type_out;
    logic [6:0]  opcode_out;
    logic [2:0]  funct3_out;
    logic [6:0]  funct7_out;
    logic [4:0]  rd_addr_out;
    logic [4:0]  rs1_addr_out;
    logic [4:0]  rs2_addr_out;
    logic        illegal_out;

    int vec_count   = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    instr_decode_stage dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .instr_in     (instr_in),
        .pc_in        (pc_in),
        .valid_in     (valid_in),
        .ready_out    (ready_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .flush_in     (flush_in),
        .pc_out       (pc_out),
        .imm_out      (imm_out),
        .imm_type_out (imm_type_out),
        .opcode_out   (opcode_out),
        .funct3_out   (funct3_out),
        .funct7_out   (funct7_out),
        .rd_addr_out  (rd_addr_out),
        .rs1_addr_out (rs1_addr_out),
        .rs2_addr_out (rs2_addr_out),
        .illegal_out  (illegal_out)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
        instr_in = instr;
        pc_in    = pc;
        valid_in = 1'b1;
    endtask

    // Decode table: instruction, expected imm_type, imm, illegal, rd, rs1
    localparam int NV = 12;
    logic [31:0] v_instr [NV] = '{
        32'hFFF10093,  // addi x1,x2,-1
        32'h3002D073,  // csrrwi x0,0x300,5
        32'h008000EF,  // jal x1,8
        32'h123452B7,  // lui x5,0x12345
        32'hFE20AE23,  // sw x2,-4(x1)
        32'hFE000CE3,  // beq x0,x0,-8
        32'h30029073,  // csrrw x0,0x300,x5
        32'h00208033,  // add x0,x1,x2
        32'h0FF0000F,  // fence
        32'h00000000,  // illegal: low bits 00
        32'hFFFFFFFF,  // illegal: opcode 1111111
        32'hFFF10091   // illegal: addi pattern, low bits 01
    };
    logic [2:0]  v_type [NV] = '{3'b001, 3'b110, 3'b101, 3'b100, 3'b010, 3'b011,
                                 3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [31:0] v_imm  [NV] = '{32'hFFFFFFFF, 32'h00000005, 32'h00000008,
                                 32'h12345000, 32'hFFFFFFFC, 32'hFFFFFFF8,
                                 32'h00000300, 32'h00000000, 32'h00000000,
                                 32'h00000000, 32'h00000000, 32'h00000000};
    logic        v_ill  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [4:0]  v_rd   [NV] = '{5'd1, 5'd0, 5'd1, 5'd5, 5'd28, 5'd25,
                                 5'd0, 5'd0, 5'd0, 5'd0, 5'd31, 5'd1};
    logic [4:0]  v_rs1  [NV] = '{5'd2, 5'd5, 5'd0, 5'd8, 5'd1, 5'd0,
                                 5'd5, 5'd1, 5'd0, 5'd0, 5'd31, 5'd2};

    initial begin
        rst_in   = 1'b1;
        instr_in = '0;
        pc_in    = '0;
        valid_in = 1'b0;
        ready_in = 1'b0;
        flush_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;

        // ---- reset state ----
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_ready", {31'd0, ready_out}, 32'd1);
        check("rst_pc", pc_out, 32'd0);
        check("rst_illegal", {31'd0, illegal_out}, 32'd0);
        $display("txn reset done");

        // ---- decode table, streamed back-to-back with ready_in=1 ----
        ready_in = 1'b1;
        for (int i = 0; i < NV; i++) begin
            offer(v_instr[i], 32'h100 + 32'(4 * i));
            tick();
            check($sformatf("dec%0d_valid", i), {31'd0, valid_out}, 32'd1);
            check($sformatf("dec%0d_pc", i), pc_out, 32'h100 + 32'(4 * i));
            check($sformatf("dec%0d_type", i), {29'd0, imm_type_out}, {29'd0, v_type[i]});
            check($sformatf("dec%0d_imm", i), imm_out, v_imm[i]);
            check($sformatf("dec%0d_illegal", i), {31'd0, illegal_out}, {31'd0, v_ill[i]});
            check($sformatf("dec%0d_rd", i), {27'd0, rd_addr_out}, {27'd0, v_rd[i]});
            check($sformatf("dec%0d_rs1", i), {27'd0, rs1_addr_out}, {27'd0, v_rs1[i]});
            check($sformatf("dec%0d_opcode", i), {25'd0, opcode_out}, {25'd0, v_instr[i][6:0]});
            $display("txn decode %0d instr=%h imm_type=%b imm=%h illegal=%b",
                     i, v_instr[i], imm_type_out, imm_out, illegal_out);
        end
        valid_in = 1'b0;
        tick();
        check("drain_valid", {31'd0, valid_out}, 32'd0);

        // ---- skid: A, B, C back-to-back with ready_in=0 ----
        ready_in = 1'b0;
        offer(32'h00100093, 32'h200);  // A: addi x1,x0,1
        tick();
        check("skidA_valid", {31'd0, valid_out}, 32'd1);
        check("skidA_pc", pc_out, 32'h200);
        check("skidA_ready", {31'd0, ready_out}, 32'd1);
        offer(32'h00200113, 32'h204);  // B: addi x2,x0,2
        tick();
        check("skidB_ready", {31'd0, ready_out}, 32'd0);
        check("skidB_hold_pc", pc_out, 32'h200);
        offer(32'h00300193, 32'h208);  // C: addi x3,x0,3, held upstream
        tick();
        check("skidC_ready", {31'd0, ready_out}, 32'd0);
        check("skidC_hold_imm", imm_out, 32'd1);
        $display("txn skid filled A,B; C stalled");
        ready_in = 1'b1;
        tick();
        check("outB_valid", {31'd0, valid_out}, 32'd1);
        check("outB_pc", pc_out, 32'h204);
        check("outB_imm", imm_out, 32'd2);
        check("outB_ready", {31'd0, ready_out}, 32'd1);
        tick();  // C accepted while B consumed
        valid_in = 1'b0;
        check("outC_valid", {31'd0, valid_out}, 32'd1);
        check("outC_pc", pc_out, 32'h208);
        check("outC_rd", {27'd0, rd_addr_out}, 32'd3);
        tick();
        check("skid_drain_valid", {31'd0, valid_out}, 32'd0);
        $display("txn skid drained A,B,C in order");

        // ---- flush while FULL with an instruction offered ----
        ready_in = 1'b0;
        offer(32'h00100093, 32'h300);
        tick();
        offer(32'h00200113, 32'h304);
        tick();
        check("fl_full_ready", {31'd0, ready_out}, 32'd0);
        flush_in = 1'b1;
        offer(32'h00400213, 32'h308);
        tick();
        flush_in = 1'b0;
        valid_in = 1'b0;
        check("fl_valid", {31'd0, valid_out}, 32'd0);
        check("fl_ready", {31'd0, ready_out}, 32'd1);
        check("fl_pc", pc_out, 32'd0);
        ready_in = 1'b1;
        tick();
        check("fl_absent", {31'd0, valid_out}, 32'd0);
        $display("txn flush from FULL");

        // ---- reset while FULL, ready_in=0, flush also asserted ----
        ready_in = 1'b0;
        offer(32'hFE20AE23, 32'h400);
        tick();
        offer(32'h3002D073, 32'h404);
        tick();
        valid_in = 1'b0;
        check("rf_full_ready", {31'd0, ready_out}, 32'd0);
        rst_in   = 1'b1;
        flush_in = 1'b1;
        tick();
        rst_in   = 1'b0;
        flush_in = 1'b0;
        check("rf_valid", {31'd0, valid_out}, 32'd0);
        check("rf_ready", {31'd0, ready_out}, 32'd1);
        check("rf_pc", pc_out, 32'd0);
        check("rf_imm", imm_out, 32'd0);
        check("rf_fields", {imm_type_out, opcode_out, funct3_out, funct7_out,
                            rd_addr_out, rs1_addr_out, 2'b00},
                           32'd0);
        check("rf_rs2", {27'd0, rs2_addr_out}, 32'd0);
        check("rf_illegal", {31'd0, illegal_out}, 32'd0);
        ready_in = 1'b1;
        tick();
        check("rf_stays_empty", {31'd0, valid_out}, 32'd0);
        $display("txn reset from FULL");

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule : tb_instr_decode_stage

// File: doc/instr_decode_stage.md
INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 The block SHALL have one clock and one reset: clk_in, input, 1, rising-edge clock; rst_in, input, 1, synchronous active-high reset.
REQ-002 The block SHALL have these upstream ports: instr_in, input, 32, fetched instruction; pc_in, input, 32, instruction address; valid_in, input, 1, instr_in/pc_in valid; ready_out, output, 1, stage can accept.
REQ-003 The block SHALL have these downstream ports: valid_out, output, 1, decoded bundle valid; ready_in, input, 1, consumer accepts; flush_in, input, 1, discard all held and incoming instructions.
REQ-004 The block SHALL have these bundle outputs: pc_out, 32; imm_out, 32; imm_type_out, 3; opcode_out, 7; funct3_out, 3; funct7_out, 7; rd_addr_out, 5; rs1_addr_out, 5; rs2_addr_out, 5; illegal_out, 1.

Function
REQ-005 An input transfer SHALL occur when valid_in && ready_out; an output transfer SHALL occur when valid_out && ready_in.
REQ-006 Latency SHALL be 1 cycle: an instruction accepted in cycle N into an empty stage SHALL appear on valid_out/bundle in cycle N+1.
REQ-007 Storage SHALL be a 2-entry skid buffer: output register (OUT) plus skid register (SKID); states EMPTY (neither valid), ONE (OUT valid), FULL (both valid).
REQ-008 ready_out SHALL be registered and equal !SKID.valid.
REQ-009 Transitions: EMPTY+accept->ONE; ONE+accept+consume->ONE (new into OUT); ONE+accept, no consume->FULL (new into SKID); ONE+consume, no accept->EMPTY; FULL+consume->ONE (SKID moves to OUT); FULL, no consume->FULL; all other combinations SHALL hold state.
REQ-010 Order SHALL be preserved; no instruction SHALL be dropped or duplicated except by flush_in.
REQ-011 flush_in SHALL take priority over all other events: next cycle EMPTY, valid_out=0, ready_out=1; an input offered in the flush cycle SHALL be discarded.
REQ-012 Bundle outputs SHALL hold stable while valid_out && !ready_in.
REQ-013 Decode SHALL be combinational on the entering instruction, with results stored in OUT/SKID; field extraction: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].
REQ-014 imm_type mapping by opcode: LOAD 0000011, OP-IMM 0010011, JALR 1100111 -> 001; STORE 0100011 -> 010; BRANCH 1100011 -> 011; LUI 0110111, AUIPC 0010111 -> 100; JAL 1101111 -> 101; SYSTEM 1110011 with funct3[2]=1 -> 110; SYSTEM with funct3[2]=0 -> 001; OP 0110011, FENCE 0001111 -> 000.
REQ-015 Immediate formats: 001 sign-extended [31:20]; 010 sign-extended {[31:25],[11:7]}; 011 sign-extended {[31],[7],[30:25],[11:8],0}; 100 {[31:12],12'h000}; 101 sign-extended {[31],[19:12],[20],[30:21],0}; 110 zero-extended [19:15]; 000 zero.
REQ-016 illegal_out SHALL be 1 when instr[1:0]!=2'b11 or the opcode is not listed in REQ-014; in that case imm_type_out SHALL be 000 and imm_out SHALL be 0.
REQ-017 The bundle SHALL be undefined-free when valid_out=0; bundle registers SHALL be cleared on reset and flush.

Reset
REQ-018 While rst_in=1 at a clock edge, the next state SHALL be: valid_out=0, SKID.valid=0, ready_out=1, and every bundle output 0 (illegal_out=0).
REQ-019 Reset mid-operation SHALL discard OUT and SKID contents regardless of handshake inputs; reset SHALL override flush_in.

Structure
REQ-020 Opcode constants and the 3-bit imm_type encodings SHALL live in a shared package/header used by the immediate generator and execute stage.
REQ-021 Immediate formation SHALL reuse the existing immediate generator as the single sub-module (imm_generator), fed instr[31:7] and the decoded imm_type; this block SHALL not duplicate that logic.

Verification
REQ-022 addi x1,x2,-1 (0xFFF10093), pc 0x100, ready_in=1 -> next cycle valid_out=1, imm_type_out=001, imm_out=0xFFFFFFFF, rd=1, rs1=2, pc_out=0x100.
REQ-023 csrrwi x0,0x300,5 (0x3002D073) -> imm_type_out=110, imm_out=0x00000005; jal x1,8 (0x008000EF) -> imm_type_out=101, imm_out=0x00000008.
REQ-024 ready_in=0, three back-to-back valid_in: A accepted to OUT, B to SKID, ready_out=0 the following cycle, C held upstream; ready_in=1 -> A, B, C emerge in order, one per cycle, no gaps after the first.
REQ-025 FULL state, flush_in=1 with valid_in=1 -> next cycle valid_out=0, ready_out=1, offered instruction absent from output.
REQ-026 Instruction 0x00000000 and 0xFFFFFFFF -> illegal_out=1, imm_type_out=000, imm_out=0.
REQ-027 rst_in pulsed while FULL with ready_in=0 -> next cycle valid_out=0, ready_out=1, all bundle outputs 0.
